// File: rtl/processor_pkg.sv
// Shared opcode constants, instruction field positions and sequencer state encoding.
package processor_pkg;

  localparam logic [3:0] OPC_ALU_NIB = 4'b0001;
  localparam logic [7:0] OPC_WRITE   = 8'h21;
  localparam logic [7:0] OPC_READ    = 8'h22;
  localparam logic [7:0] OPC_NOP     = 8'h00;
  localparam logic [7:0] OPC_HALT    = 8'hFF;

  localparam int INSTR_W = 48;
  localparam int OP_MSB  = 47;
  localparam int OP_LSB  = 32;
  localparam int A1_MSB  = 31;
  localparam int A1_LSB  = 28;
  localparam int A2_MSB  = 27;
  localparam int A2_LSB  = 24;
  localparam int A3_MSB  = 23;
  localparam int A3_LSB  = 20;
  localparam int RSV_MSB = 19;
  localparam int RSV_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of a 48-bit instruction word into fields plus opcode class flags.
module instr_decoder
  import processor_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [15:0]        op_word_o,
  output logic [3:0]         addr_1_o,
  output logic [3:0]         addr_2_o,
  output logic [3:0]         addr_3_o,
  output logic [15:0]        imm_o,
  output logic               is_alu_o,
  output logic               is_write_o,
  output logic               is_read_o,
  output logic               is_halt_o,
  output logic               is_illegal_o
);

  logic [7:0] opc;
  logic       is_nop;
  logic       unused_rsv;

  assign op_word_o  = instr_i[OP_MSB:OP_LSB];
  assign addr_1_o   = instr_i[A1_MSB:A1_LSB];
  assign addr_2_o   = instr_i[A2_MSB:A2_LSB];
  assign addr_3_o   = instr_i[A3_MSB:A3_LSB];
  assign imm_o      = instr_i[IMM_MSB:IMM_LSB];
  assign unused_rsv = ^instr_i[RSV_MSB:RSV_LSB];

  assign opc = op_word_o[15:8];

  assign is_alu_o     = (opc[7:4] == OPC_ALU_NIB);
  assign is_write_o   = (opc == OPC_WRITE);
  assign is_read_o    = (opc == OPC_READ);
  assign is_halt_o    = (opc == OPC_HALT);
  assign is_nop       = (opc == OPC_NOP);
  assign is_illegal_o = !(is_alu_o || is_write_o || is_read_o || is_halt_o || is_nop);

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/issue controller: fetches, decodes and issues one instruction per ISSUE cycle until HALT.
// SEQ_SINGLE_STEP_EN adds a step input that holds ISSUE until step is high.
module instruction_sequencer
  import processor_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_valid,
  input  logic [47:0]           imem_data,
  output logic [DATA_WIDTH-1:0] op,
  output logic [3:0]            addr_1,
  output logic [3:0]            addr_2,
  output logic [3:0]            addr_3,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] read_data_reg,
  output logic [DATA_WIDTH-1:0] read_value,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal
);

  seq_state_e            state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [INSTR_W-1:0]    ir_q;
  logic [DATA_WIDTH-1:0] read_value_q;
  logic                  read_valid_q;
  logic                  illegal_q;

  logic [15:0] dec_op;
  logic [3:0]  dec_a1, dec_a2, dec_a3;
  logic [15:0] dec_imm;
  logic        dec_alu, dec_write, dec_read, dec_halt, dec_illegal;
  logic        issue_done_d;
  logic        in_issue;

  instr_decoder u_dec (
    .instr_i      (ir_q),
    .op_word_o    (dec_op),
    .addr_1_o     (dec_a1),
    .addr_2_o     (dec_a2),
    .addr_3_o     (dec_a3),
    .imm_o        (dec_imm),
    .is_alu_o     (dec_alu),
    .is_write_o   (dec_write),
    .is_read_o    (dec_read),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign issue_done_d = step;
`else
  assign issue_done_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      read_value_q <= '0;
      read_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      read_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc_q      <= '0;
            illegal_q <= 1'b0;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dec_illegal) illegal_q <= 1'b1;
          if (issue_done_d) begin
            if (dec_read) begin
              read_value_q <= read_data_reg;
              read_valid_q <= 1'b1;
            end
            // HALT leaves pc pointing at the HALT instruction itself.
            if (dec_halt) begin
              state_q <= ST_HALTED;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_issue = (state_q == ST_ISSUE);

  // Everything the register file sees is gated by ISSUE, so reset or idle can never commit a write.
  always_comb begin
    op         = '0;
    addr_1     = '0;
    addr_2     = '0;
    addr_3     = '0;
    write_data = '0;
    if (in_issue && !dec_illegal) begin
      op     = DATA_WIDTH'(dec_op);
      addr_1 = dec_a1;
      addr_2 = dec_a2;
      addr_3 = dec_a3;
      if (dec_alu)        write_data = alu_result;
      else if (dec_write) write_data = DATA_WIDTH'(dec_imm);
    end
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign busy       = (state_q == ST_FETCH) || in_issue;
  assign halted     = (state_q == ST_HALTED);
  assign illegal    = illegal_q;
  assign read_value = read_value_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench: program memory, tiny register file model, immediate-assertion checks.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, imem_valid;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [47:0] imem_data;
  logic [15:0] op, write_data, alu_result, read_data_reg, read_value;
  logic [3:0]  addr_1, addr_2, addr_3;
  logic        read_valid, busy, halted, illegal;

  logic        start2, req2, busy2;
  logic [1:0]  addr2;
  logic [47:0] data2;
  logic [15:0] d2_unused_op, d2_unused_wd, d2_unused_rv;
  logic [3:0]  d2_unused_a1, d2_unused_a2, d2_unused_a3;
  logic        d2_unused_rvl, d2_unused_halt, d2_unused_ill;

  logic [47:0] mem  [256];
  logic [47:0] mem2 [4];
  logic [15:0] regs [16];
  int          rf_writes = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_data     = mem[imem_addr];
  assign data2         = mem2[addr2];
  assign read_data_reg = regs[addr_1];

  always @(posedge clk) begin
    if (op[15:8] == 8'h21 || op[15:12] == 4'h1) begin
      regs[addr_3] <= write_data;
      rf_writes    <= rf_writes + 1;
    end
  end

  instruction_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .op(op), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3), .write_data(write_data),
    .alu_result(alu_result), .read_data_reg(read_data_reg),
    .read_value(read_value), .read_valid(read_valid),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  instruction_sequencer #(.PC_WIDTH(2), .DATA_WIDTH(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .imem_req(req2), .imem_addr(addr2), .imem_valid(1'b1), .imem_data(data2),
    .op(d2_unused_op), .addr_1(d2_unused_a1), .addr_2(d2_unused_a2), .addr_3(d2_unused_a3),
    .write_data(d2_unused_wd), .alu_result(16'h0000), .read_data_reg(16'h0000),
    .read_value(d2_unused_rv), .read_valid(d2_unused_rvl),
    .busy(busy2), .halted(d2_unused_halt), .illegal(d2_unused_ill)
  );

  function automatic logic [47:0] mk(input logic [15:0] o, input logic [3:0] a1,
                                     input logic [3:0] a2, input logic [3:0] a3,
                                     input logic [15:0] imm);
    return {o, a1, a2, a3, 4'h0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    logic [1:0]  exp_a [5];
    logic [15:0] rv;
    int          pulses, n, snap;

    exp_a      = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset_n    = 1'b0;
    start      = 1'b0;
    start2     = 1'b0;
    imem_valid = 1'b1;
    alu_result = 16'd12;
    for (int i = 0; i < 256; i++) mem[i] = mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'h0000);
    for (int i = 0; i < 4; i++)   mem2[i] = mk(16'h2100, 4'h0, 4'h0, 4'(i), 16'(i + 1));

    // reset state
    #12;
    chk("rst_op",      {16'd0, op}, 32'd0);
    chk("rst_wd",      {16'd0, write_data}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_halted",  {31'd0, halted}, 32'd0);
    chk("rst_req",     {31'd0, imem_req}, 32'd0);
    chk("rst_addr",    {24'd0, imem_addr}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_rvalid",  {31'd0, read_valid}, 32'd0);
    chk("rst_rvalue",  {16'd0, read_value}, 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_ignores_valid", {31'd0, busy}, 32'd0);

    // WRITE r3<-0x1234 then HALT, zero-wait memory
    mem[0] = mk(16'h2100, 4'h0, 4'h0, 4'h3, 16'h1234);
    mem[1] = mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_fetch_req",  {31'd0, imem_req}, 32'd1);
    chk("t1_fetch_addr", {24'd0, imem_addr}, 32'd0);
    chk("t1_fetch_op",   {16'd0, op}, 32'd0);
    tick();
    chk("t1_issue_op", {16'd0, op}, 32'h2100);
    chk("t1_issue_a3", {28'd0, addr_3}, 32'd3);
    chk("t1_issue_wd", {16'd0, write_data}, 32'h1234);
    tick();
    chk("t1_fetch2_addr", {24'd0, imem_addr}, 32'd1);
    chk("t1_fetch2_op",   {16'd0, op}, 32'd0);
    tick();
    chk("t1_halt_issue_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("t1_halted", {31'd0, halted}, 32'd1);
    chk("t1_busy",   {31'd0, busy}, 32'd0);
    chk("t1_reg3",   {16'd0, regs[3]}, 32'h1234);

    // WRITE r1<-5, WRITE r2<-7, ALU r3=r1+r2, READ r3, HALT
    mem[0] = mk(16'h2100, 4'h0, 4'h0, 4'h1, 16'd5);
    mem[1] = mk(16'h2100, 4'h0, 4'h0, 4'h2, 16'd7);
    mem[2] = mk(16'h1000, 4'h1, 4'h2, 4'h3, 16'd0);
    mem[3] = mk(16'h2200, 4'h3, 4'h0, 4'h0, 16'd0);
    mem[4] = mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    rv = 16'h0;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      if (read_valid === 1'b1) begin
        pulses++;
        rv = read_value;
      end
      tick();
      n++;
    end
    chk("t2_halt_reached", {31'd0, halted}, 32'd1);
    chk("t2_pulses",       pulses, 32'd1);
    chk("t2_pulse_value",  {16'd0, rv}, 32'd12);
    chk("t2_read_value",   {16'd0, read_value}, 32'd12);
    chk("t2_reg1",         {16'd0, regs[1]}, 32'd5);
    chk("t2_reg3",         {16'd0, regs[3]}, 32'd12);

    // memory wait states: request held, no issue until valid
    mem[0] = mk(16'h2100, 4'h0, 4'h0, 4'h5, 16'hBEEF);
    mem[1] = mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'd0);
    imem_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_wait_req",  {31'd0, imem_req}, 32'd1);
      chk("t3_wait_addr", {24'd0, imem_addr}, 32'd0);
      chk("t3_wait_op",   {16'd0, op}, 32'd0);
      tick();
    end
    chk("t3_still_fetch", {31'd0, imem_req}, 32'd1);
    imem_valid = 1'b1;
    tick();
    chk("t3_issue_op", {16'd0, op}, 32'h2100);
    chk("t3_issue_wd", {16'd0, write_data}, 32'hBEEF);
    wait_halt("t3_halt_reached");

    // unknown opcode issues as NOP, sets sticky illegal, start clears it
    mem[0] = mk(16'h7700, 4'h1, 4'h2, 4'h3, 16'h5555);
    mem[1] = mk(16'h2100, 4'h0, 4'h0, 4'h6, 16'h0042);
    mem[2] = mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t4_illegal_op", {16'd0, op}, 32'd0);
    chk("t4_illegal_wd", {16'd0, write_data}, 32'd0);
    tick();
    chk("t4_illegal_set", {31'd0, illegal}, 32'd1);
    chk("t4_continue_addr", {24'd0, imem_addr}, 32'd1);
    tick();
    chk("t4_next_op", {16'd0, op}, 32'h2100);
    chk("t4_next_wd", {16'd0, write_data}, 32'h0042);
    wait_halt("t4_halt_reached");
    chk("t4_illegal_sticky", {31'd0, illegal}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_illegal_cleared", {31'd0, illegal}, 32'd0);
    chk("t4_restart_busy", {31'd0, busy}, 32'd1);
    wait_halt("t4_halt_reached2");

    // PC_WIDTH=2 instance wraps 3 -> 0
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_wrap_req",  {31'd0, req2}, 32'd1);
      chk("t5_wrap_addr", {30'd0, addr2}, {30'd0, exp_a[k]});
      tick();
      tick();
    end

    // reset during ISSUE of a WRITE aborts it
    mem[0] = mk(16'h2100, 4'h0, 4'h0, 4'h9, 16'hAAAA);
    mem[1] = mk(16'hFF00, 4'h0, 4'h0, 4'h0, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_issue_op", {16'd0, op}, 32'h2100);
    snap = rf_writes;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_op",     {16'd0, op}, 32'd0);
    chk("t6_rst_wd",     {16'd0, write_data}, 32'd0);
    chk("t6_rst_a3",     {28'd0, addr_3}, 32'd0);
    chk("t6_rst_busy",   {31'd0, busy}, 32'd0);
    chk("t6_rst_req",    {31'd0, imem_req}, 32'd0);
    chk("t6_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("t6_no_write", rf_writes, snap);
    chk("t6_dut2_rst", {31'd0, busy2}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("t6_idle_busy",   {31'd0, busy}, 32'd0);
    chk("t6_idle_halted", {31'd0, halted}, 32'd0);
    chk("t6_idle_req",    {31'd0, imem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
